control_multiciclo: RTL and testbench



---
 rtl/control_multiciclo_pkg.sv | 89 ++++++++
 rtl/control_salidas.sv | 98 +++++++++
 rtl/control_multiciclo.sv | 147 ++++++++++++++
 tb/tb_control_multiciclo.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/control_multiciclo_pkg.sv
// Shared definitions for the multi-cycle MIPS32 main control FSM:
// state encodings, opcode constants, datapath select codes and the
// control-line bundle passed from the output decoder to the top.
package control_multiciclo_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  // Encodings 12..15 are unused and recover to FETCH.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;

  // ALUop codes understood by ALU control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // ALU operand A select
  localparam logic SRCA_PC  = 1'b0;
  localparam logic SRCA_REG = 1'b1;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control lines driven each cycle
  typedef struct packed {
    logic       mem_read;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // I-type ALU opcodes that share the I_EXEC/I_WB path
  function automatic logic is_itype_alu(input logic [OP_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_XORI) || (op == OP_SLTI);
  endfunction

  // Selector handed to ALU control: funct for R-type, opcode otherwise
  function automatic logic [OP_W-1:0] fnc_select(input logic [OP_W-1:0] op,
                                                 input logic [OP_W-1:0] fn);
    return (op == OP_RTYPE) ? fn : op;
  endfunction

endpackage

// File: rtl/control_salidas.sv
// Combinational decode of the control state into datapath control lines.
// Architectural write enables are held off until the FSM is running so a
// freshly reset core never commits a write in its first cycle.
module control_salidas
  import control_multiciclo_pkg::*;
(
  input  state_t state_i,
  input  logic   run_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_c
);

  ctrl_t base;

  // Per-state control lines; anything not named for a state stays 0
  always_comb begin
    base = CTRL_IDLE;
    case (state_i)
      S_FETCH: begin
        base.mem_read  = 1'b1;
        base.iord      = 1'b0;
        base.alu_src_a = SRCA_PC;
        base.alu_src_b = SRCB_FOUR;
        base.alu_op    = ALUOP_ADD;
        base.pc_source = PCSRC_ALU;
        base.ir_write  = mem_ready_i;
        base.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        base.alu_src_a = SRCA_PC;
        base.alu_src_b = SRCB_IMM_SH2;
        base.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        base.alu_src_a = SRCA_REG;
        base.alu_src_b = SRCB_IMM;
        base.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        base.mem_read = 1'b1;
        base.iord     = 1'b1;
      end
      S_MEM_WB: begin
        base.reg_write  = 1'b1;
        base.reg_dst    = 1'b0;
        base.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        base.mem_write = 1'b1;
        base.iord      = 1'b1;
      end
      S_R_EXEC: begin
        base.alu_src_a = SRCA_REG;
        base.alu_src_b = SRCB_REG;
        base.alu_op    = ALUOP_RTYPE;
      end
      S_R_WB: begin
        base.reg_write  = 1'b1;
        base.reg_dst    = 1'b1;
        base.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        base.alu_src_a     = SRCA_REG;
        base.alu_src_b     = SRCB_REG;
        base.alu_op        = ALUOP_SUB;
        base.pc_write_cond = 1'b1;
        base.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        base.pc_write  = 1'b1;
        base.pc_source = PCSRC_JUMP;
      end
      S_I_EXEC: begin
        base.alu_src_a = SRCA_REG;
        base.alu_src_b = SRCB_IMM;
        base.alu_op    = ALUOP_ITYPE;
      end
      S_I_WB: begin
        base.reg_write  = 1'b1;
        base.reg_dst    = 1'b0;
        base.mem_to_reg = 1'b0;
      end
      default: base = CTRL_IDLE;
    endcase
  end

  // Suppress architectural writes until the first post-reset clock
  always_comb begin
    ctrl_c = base;
    if (!run_i) begin
      ctrl_c.ir_write  = 1'b0;
      ctrl_c.pc_write  = 1'b0;
      ctrl_c.mem_write = 1'b0;
      ctrl_c.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multi-cycle MIPS32 main control: owns the state register, next-state
// logic, the ALU-control selector latched in DECODE, the run gate and
// the retired-instruction counter. Control lines come from control_salidas.
module control_multiciclo
  import control_multiciclo_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic [1:0]       ALUop,
  output logic [5:0]       fnc_o,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [OP_W-1:0]  fnc_q, fnc_d;
  logic             run_q, run_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  ctrl_t            ctrl;

  // State, selector, run gate and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      fnc_q     <= '0;
      run_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      fnc_q     <= fnc_d;
      run_q     <= run_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, DECODE latch, illegal pulse and retire detection
  always_comb begin
    state_d   = state_q;
    fnc_d     = fnc_q;
    run_d     = 1'b1;
    retire    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        // The first fetch after reset waits for run so no IR/PC write is lost
        if (run_q && mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        fnc_d = fnc_select(opcode, funct);
        if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          state_d = S_MEM_ADDR;
        end else if (opcode == OP_RTYPE) begin
          state_d = S_R_EXEC;
        end else if (is_itype_alu(opcode)) begin
          state_d = S_I_EXEC;
        end else if (opcode == OP_BEQ) begin
          state_d = S_BRANCH;
        end else if (opcode == OP_J) begin
          state_d = S_JUMP;
        end else begin
          state_d = S_FETCH;
          illegal = 1'b1;
        end
      end
      S_MEM_ADDR: begin
        state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_R_EXEC: state_d = S_R_WB;
      S_R_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_I_EXEC: state_d = S_I_WB;
      S_I_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
  end

  control_salidas u_salidas (
    .state_i     (state_q),
    .run_i       (run_q),
    .mem_ready_i (mem_ready),
    .ctrl_c      (ctrl)
  );

  assign ALUop       = ctrl.alu_op;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign PCSource    = ctrl.pc_source;
  assign fnc_o       = fnc_q;
  assign state_o     = 4'(state_q);
  assign retired     = retired_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// Scoreboard bench for control_multiciclo: the stimulus process pushes the
// hand-derived expected state/counter/selector for every driven cycle; a
// monitor pops each entry on the falling edge and checks the DUT outputs.
module tb_control_multiciclo;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BAD = 6'h3F;
  localparam logic [5:0] F_ADD  = 6'h20;

  typedef struct packed {
    logic [3:0]  st;
    logic        run;
    logic        mr;
    logic [31:0] ret;
    logic [5:0]  fnc;
    logic        ill;
    logic [15:0] tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        mem_ready;
  logic [1:0]  ALUop, ALUSrcB, PCSource;
  logic [5:0]  fnc_o;
  logic        ALUSrcA, IorD, MemRead, MemWrite, IRWrite;
  logic        RegDst, RegWrite, MemtoReg, PCWrite, PCWriteCond, illegal;
  logic [3:0]  state_o;
  logic [31:0] retired;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc_tag  = 0;

  control_multiciclo #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .ALUop(ALUop), .fnc_o(fnc_o),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .illegal(illegal), .state_o(state_o), .retired(retired)
  );

  always #5 clk = ~clk;

  // Expected control word per state, in the order
  // {MemRead,IorD,MemWrite,IRWrite,RegDst,RegWrite,MemtoReg,PCWrite,
  //  PCWriteCond,PCSource,ALUSrcA,ALUSrcB,ALUop}
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic run,
                                           input logic mr);
    logic mrd, iod, mw, irw, rd, rw, m2r, pcw, pcc, sa;
    logic [1:0] ps, sb, aop;
    {mrd, iod, mw, irw, rd, rw, m2r, pcw, pcc, sa} = '0;
    ps = 2'b00; sb = 2'b00; aop = 2'b00;
    case (st)
      4'd0:  begin mrd = 1'b1; sb = 2'b01; irw = mr & run; pcw = mr & run; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1'b1; sb = 2'b10; end
      4'd3:  begin mrd = 1'b1; iod = 1'b1; end
      4'd4:  begin rw = run; m2r = 1'b1; end
      4'd5:  begin mw = run; iod = 1'b1; end
      4'd6:  begin sa = 1'b1; aop = 2'b10; end
      4'd7:  begin rw = run; rd = 1'b1; end
      4'd8:  begin sa = 1'b1; aop = 2'b01; pcc = 1'b1; ps = 2'b01; end
      4'd9:  begin pcw = run; ps = 2'b10; end
      4'd10: begin sa = 1'b1; sb = 2'b10; aop = 2'b11; end
      4'd11: rw = run;
      default: ;
    endcase
    return {mrd, iod, mw, irw, rd, rw, m2r, pcw, pcc, ps, sa, sb, aop};
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show this cycle
  task automatic step(input logic rst, input logic mr, input logic [5:0] op,
                      input logic [5:0] fn, input logic [3:0] st, input logic run,
                      input logic [31:0] ret, input logic [5:0] fnc, input logic ill);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; mem_ready = mr; opcode = op; funct = fn;
    cyc_tag = cyc_tag + 1;
    e.st = st; e.run = run; e.mr = mr; e.ret = ret; e.fnc = fnc; e.ill = ill;
    e.tag = 16'(cyc_tag);
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] tag,
                     input logic [31:0] got, input logic [31:0] want);
    n_checks = n_checks + 1;
    if (got !== want) begin
      n_fail = n_fail + 1;
      $display("FAIL %s step=%0d got=%h want=%h", name, tag, got, want);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] got_ctrl;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      got_ctrl = {MemRead, IorD, MemWrite, IRWrite, RegDst, RegWrite, MemtoReg,
                  PCWrite, PCWriteCond, PCSource, ALUSrcA, ALUSrcB, ALUop};
      chk("state",   e.tag, 32'(state_o),  32'(e.st));
      chk("ctrl",    e.tag, 32'(got_ctrl), 32'(exp_ctrl(e.st, e.run, e.mr)));
      chk("retired", e.tag, retired,       e.ret);
      chk("fnc_o",   e.tag, 32'(fnc_o),    32'(e.fnc));
      chk("illegal", e.tag, 32'(illegal),  32'(e.ill));
    end
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_R; funct = F_ADD;
    // reset held, then add with mem_ready=1: states 0,0,1,6,7,0
    step(0, 1, OP_R, F_ADD, 4'd0, 0, 0, 6'h00, 0);
    step(0, 1, OP_R, F_ADD, 4'd0, 0, 0, 6'h00, 0);
    step(1, 1, OP_R, F_ADD, 4'd0, 0, 0, 6'h00, 0);
    step(1, 1, OP_R, F_ADD, 4'd0, 1, 0, 6'h00, 0);
    step(1, 1, OP_R, F_ADD, 4'd1, 1, 0, 6'h00, 0);
    step(1, 1, OP_R, F_ADD, 4'd6, 1, 0, F_ADD, 0);
    step(1, 1, OP_R, F_ADD, 4'd7, 1, 0, F_ADD, 0);
    // lw: 2 wait cycles in FETCH, 3 in MEM_READ -> 10 cycles
    step(1, 0, OP_LW, 6'h00, 4'd0, 1, 1, F_ADD, 0);
    step(1, 0, OP_LW, 6'h00, 4'd0, 1, 1, F_ADD, 0);
    step(1, 1, OP_LW, 6'h00, 4'd0, 1, 1, F_ADD, 0);
    step(1, 1, OP_LW, 6'h00, 4'd1, 1, 1, F_ADD, 0);
    step(1, 1, OP_LW, 6'h00, 4'd2, 1, 1, OP_LW, 0);
    step(1, 0, OP_LW, 6'h00, 4'd3, 1, 1, OP_LW, 0);
    step(1, 0, OP_LW, 6'h00, 4'd3, 1, 1, OP_LW, 0);
    step(1, 0, OP_LW, 6'h00, 4'd3, 1, 1, OP_LW, 0);
    step(1, 1, OP_LW, 6'h00, 4'd3, 1, 1, OP_LW, 0);
    step(1, 1, OP_LW, 6'h00, 4'd4, 1, 1, OP_LW, 0);
    // ori
    step(1, 1, OP_ORI, 6'h00, 4'd0,  1, 2, OP_LW,  0);
    step(1, 1, OP_ORI, 6'h00, 4'd1,  1, 2, OP_LW,  0);
    step(1, 1, OP_ORI, 6'h00, 4'd10, 1, 2, OP_ORI, 0);
    step(1, 1, OP_ORI, 6'h00, 4'd11, 1, 2, OP_ORI, 0);
    // beq then j
    step(1, 1, OP_BEQ, 6'h00, 4'd0, 1, 3, OP_ORI, 0);
    step(1, 1, OP_BEQ, 6'h00, 4'd1, 1, 3, OP_ORI, 0);
    step(1, 1, OP_BEQ, 6'h00, 4'd8, 1, 3, OP_BEQ, 0);
    step(1, 1, OP_J,   6'h00, 4'd0, 1, 4, OP_BEQ, 0);
    step(1, 1, OP_J,   6'h00, 4'd1, 1, 4, OP_BEQ, 0);
    step(1, 1, OP_J,   6'h00, 4'd9, 1, 4, OP_J,   0);
    // illegal opcode: one-cycle pulse in DECODE, counter untouched
    step(1, 1, OP_BAD, 6'h00, 4'd0, 1, 5, OP_J, 0);
    step(1, 1, OP_BAD, 6'h00, 4'd1, 1, 5, OP_J, 1);
    // sw with one wait cycle in MEM_WRITE
    step(1, 1, OP_SW, 6'h00, 4'd0, 1, 5, OP_BAD, 0);
    step(1, 1, OP_SW, 6'h00, 4'd1, 1, 5, OP_BAD, 0);
    step(1, 1, OP_SW, 6'h00, 4'd2, 1, 5, OP_SW,  0);
    step(1, 0, OP_SW, 6'h00, 4'd5, 1, 5, OP_SW,  0);
    step(1, 1, OP_SW, 6'h00, 4'd5, 1, 5, OP_SW,  0);
    // second sw, reset asserted while MEM_WRITE waits
    step(1, 1, OP_SW, 6'h00, 4'd0, 1, 6, OP_SW, 0);
    step(1, 1, OP_SW, 6'h00, 4'd1, 1, 6, OP_SW, 0);
    step(1, 1, OP_SW, 6'h00, 4'd2, 1, 6, OP_SW, 0);
    step(1, 0, OP_SW, 6'h00, 4'd5, 1, 6, OP_SW, 0);
    step(0, 0, OP_SW, 6'h00, 4'd0, 0, 0, 6'h00, 0);
    step(1, 1, OP_SW, 6'h00, 4'd0, 0, 0, 6'h00, 0);
    step(1, 1, OP_SW, 6'h00, 4'd0, 1, 0, 6'h00, 0);
    step(1, 1, OP_SW, 6'h00, 4'd1, 1, 0, 6'h00, 0);

    // bounded drain of the scoreboard
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
